// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants for the AXI read-path arbiter: FSM encodings, slave decode and select codes.
package axi_rd_arbiter_pkg;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAr   = 3'd1;
  localparam logic [2:0] StR    = 3'd2;
  localparam logic [2:0] StDar  = 3'd3;
  localparam logic [2:0] StDr   = 3'd4;

  localparam logic [1:0] HiUnmapped = 2'b00;
  localparam logic [1:0] HiS0       = 2'b01;
  localparam logic [1:0] HiS1       = 2'b10;
  localparam logic [1:0] HiS2       = 2'b11;

  localparam logic [2:0] SelNone = 3'b000;
  localparam logic [2:0] SelS0   = 3'b001;
  localparam logic [2:0] SelS1   = 3'b010;
  localparam logic [2:0] SelS2   = 3'b100;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [2:0] slave_sel(input logic [1:0] hi);
    case (hi)
      HiS0:    slave_sel = SelS0;
      HiS1:    slave_sel = SelS1;
      HiS2:    slave_sel = SelS2;
      default: slave_sel = SelNone;
    endcase
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_arb3.sv
// Three-way round-robin arbiter; the pointer remembers the last granted requester.
module rr_arb3 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] req_i,
  input  logic       upd_i,
  input  logic [2:0] upd_gnt_i,
  output logic [2:0] gnt_o
);

  logic [2:0] ptr_q;

  // Search starts at the requester after the one last granted.
  always_comb begin
    gnt_o = 3'b000;
    case (ptr_q)
      3'b001: begin
        if (req_i[1])      gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
      end
      3'b010: begin
        if (req_i[2])      gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
      end
      default: begin
        if (req_i[0])      gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 3'b100;
    end else if (upd_i) begin
      ptr_q <= upd_gnt_i;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// AXI read-path arbiter: round-robin AR grant, R-route sequencing, one transaction in flight.
// Define AXI_RD_DECERR_EN to serve addr_hi = 00 from an internal decode-error slave.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned RESP_WIDTH = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rstn,
  input  logic                  m0_arvalid,
  input  logic                  m1_arvalid,
  input  logic                  m2_arvalid,
  input  logic [1:0]            m0_araddr_hi,
  input  logic [1:0]            m1_araddr_hi,
  input  logic [1:0]            m2_araddr_hi,
  input  logic                  s_arvalid,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [7:0]            s_arlen,
  input  logic                  m_arready,
  input  logic                  m_rvalid,
  input  logic                  m_rlast,
  input  logic                  s_rready,
  output logic [2:0]            ar_grant,
  output logic                  s_araddr_en,
  output logic [2:0]            rvalid_sel,
  output logic                  m_rvalid_sel_en,
  output logic                  busy,
  output logic                  dec_arready,
  output logic                  dec_rvalid,
  output logic                  dec_rlast,
  output logic [ID_WIDTH-1:0]   dec_rid,
  output logic [RESP_WIDTH-1:0] dec_rresp
);

  logic [2:0]            state_q, state_d;
  logic [2:0]            ar_grant_q, ar_grant_d;
  logic                  s_araddr_en_q, s_araddr_en_d;
  logic [2:0]            rvalid_sel_q, rvalid_sel_d;
  logic                  m_rvalid_sel_en_q, m_rvalid_sel_en_d;
  logic                  busy_q, busy_d;
  logic                  dec_arready_q, dec_arready_d;
  logic                  dec_rvalid_q, dec_rvalid_d;
  logic                  dec_rlast_q, dec_rlast_d;
  logic [ID_WIDTH-1:0]   dec_rid_q, dec_rid_d;
  logic [RESP_WIDTH-1:0] dec_rresp_q, dec_rresp_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;

  logic [2:0] elig, arb_gnt;
  logic       arb_upd;
  logic [1:0] win_hi, gnt_hi;

`ifdef AXI_RD_DECERR_EN
  assign elig = {m2_arvalid, m1_arvalid, m0_arvalid};
`else
  assign elig = {m2_arvalid & (|m2_araddr_hi), m1_arvalid & (|m1_araddr_hi),
                 m0_arvalid & (|m0_araddr_hi)};
  logic unused_dec_inputs;
  assign unused_dec_inputs = ^{s_arid, s_arlen, win_hi};
`endif

  assign win_hi = ({2{arb_gnt[0]}} & m0_araddr_hi) | ({2{arb_gnt[1]}} & m1_araddr_hi) |
                  ({2{arb_gnt[2]}} & m2_araddr_hi);
  assign gnt_hi = ({2{ar_grant_q[0]}} & m0_araddr_hi) | ({2{ar_grant_q[1]}} & m1_araddr_hi) |
                  ({2{ar_grant_q[2]}} & m2_araddr_hi);

  rr_arb3 u_arb (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rstn),
    .req_i     (elig),
    .upd_i     (arb_upd),
    .upd_gnt_i (ar_grant_q),
    .gnt_o     (arb_gnt)
  );

  always_comb begin
    state_d           = state_q;
    ar_grant_d        = ar_grant_q;
    s_araddr_en_d     = s_araddr_en_q;
    rvalid_sel_d      = rvalid_sel_q;
    m_rvalid_sel_en_d = m_rvalid_sel_en_q;
    busy_d            = busy_q;
    dec_arready_d     = dec_arready_q;
    dec_rvalid_d      = dec_rvalid_q;
    dec_rlast_d       = dec_rlast_q;
    dec_rid_d         = dec_rid_q;
    dec_rresp_d       = dec_rresp_q;
    beat_cnt_d        = beat_cnt_q;
    arb_upd           = 1'b0;
    case (state_q)
      StIdle: begin
        if (|arb_gnt) begin
          ar_grant_d = arb_gnt;
          busy_d     = 1'b1;
`ifdef AXI_RD_DECERR_EN
          if (win_hi == HiUnmapped) begin
            state_d       = StDar;
            dec_arready_d = 1'b1;
          end else
`endif
          begin
            state_d       = StAr;
            s_araddr_en_d = 1'b1;
          end
        end
      end
      StAr: begin
        if (s_arvalid && m_arready) begin
          state_d           = StR;
          s_araddr_en_d     = 1'b0;
          rvalid_sel_d      = slave_sel(gnt_hi);
          m_rvalid_sel_en_d = 1'b1;
        end
      end
      StR: begin
        if (m_rvalid && s_rready && m_rlast) begin
          state_d           = StIdle;
          arb_upd           = 1'b1;
          ar_grant_d        = SelNone;
          rvalid_sel_d      = SelNone;
          m_rvalid_sel_en_d = 1'b0;
          busy_d            = 1'b0;
        end
      end
`ifdef AXI_RD_DECERR_EN
      StDar: begin
        if (s_arvalid) begin
          state_d       = StDr;
          dec_arready_d = 1'b0;
          dec_rid_d     = s_arid;
          beat_cnt_d    = s_arlen;
          dec_rvalid_d  = 1'b1;
          dec_rresp_d   = RESP_WIDTH'(RESP_DECERR);
          dec_rlast_d   = (s_arlen == 8'd0);
        end
      end
      StDr: begin
        if (s_rready) begin
          if (beat_cnt_q == 8'd0) begin
            state_d      = StIdle;
            arb_upd      = 1'b1;
            ar_grant_d   = SelNone;
            busy_d       = 1'b0;
            dec_rvalid_d = 1'b0;
            dec_rlast_d  = 1'b0;
            dec_rid_d    = '0;
            dec_rresp_d  = '0;
          end else begin
            beat_cnt_d  = beat_cnt_q - 8'd1;
            dec_rlast_d = (beat_cnt_q == 8'd1);
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q           <= StIdle;
      ar_grant_q        <= SelNone;
      s_araddr_en_q     <= 1'b0;
      rvalid_sel_q      <= SelNone;
      m_rvalid_sel_en_q <= 1'b0;
      busy_q            <= 1'b0;
      dec_arready_q     <= 1'b0;
      dec_rvalid_q      <= 1'b0;
      dec_rlast_q       <= 1'b0;
      dec_rid_q         <= '0;
      dec_rresp_q       <= '0;
      beat_cnt_q        <= 8'd0;
    end else begin
      state_q           <= state_d;
      ar_grant_q        <= ar_grant_d;
      s_araddr_en_q     <= s_araddr_en_d;
      rvalid_sel_q      <= rvalid_sel_d;
      m_rvalid_sel_en_q <= m_rvalid_sel_en_d;
      busy_q            <= busy_d;
      dec_arready_q     <= dec_arready_d;
      dec_rvalid_q      <= dec_rvalid_d;
      dec_rlast_q       <= dec_rlast_d;
      dec_rid_q         <= dec_rid_d;
      dec_rresp_q       <= dec_rresp_d;
      beat_cnt_q        <= beat_cnt_d;
    end
  end

  // Without the decode-error slave the dec_* registers never leave reset, so they read as 0.
  assign ar_grant        = ar_grant_q;
  assign s_araddr_en     = s_araddr_en_q;
  assign rvalid_sel      = rvalid_sel_q;
  assign m_rvalid_sel_en = m_rvalid_sel_en_q;
  assign busy            = busy_q;
  assign dec_arready     = dec_arready_q;
  assign dec_rvalid      = dec_rvalid_q;
  assign dec_rlast       = dec_rlast_q;
  assign dec_rid         = dec_rid_q;
  assign dec_rresp       = dec_rresp_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: reset, round robin, burst hold, AR stall, decode error, reset.
module tb_axi_rd_arbiter;

  logic       sys_clk = 1'b0;
  logic       sys_rstn;
  logic       m0_arvalid, m1_arvalid, m2_arvalid;
  logic [1:0] m0_araddr_hi, m1_araddr_hi, m2_araddr_hi;
  logic       s_arvalid;
  logic [3:0] s_arid;
  logic [7:0] s_arlen;
  logic       m_arready, m_rvalid, m_rlast, s_rready;
  logic [2:0] ar_grant, rvalid_sel;
  logic       s_araddr_en, m_rvalid_sel_en, busy;
  logic       dec_arready, dec_rvalid, dec_rlast;
  logic [3:0] dec_rid;
  logic [1:0] dec_rresp;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  always #5 sys_clk = ~sys_clk;

  // Models the upstream master mux: the granted master's arvalid.
  assign s_arvalid = |(ar_grant & {m2_arvalid, m1_arvalid, m0_arvalid});

  axi_rd_arbiter #(.ID_WIDTH(4), .RESP_WIDTH(2)) dut (
    .sys_clk         (sys_clk),
    .sys_rstn        (sys_rstn),
    .m0_arvalid      (m0_arvalid),
    .m1_arvalid      (m1_arvalid),
    .m2_arvalid      (m2_arvalid),
    .m0_araddr_hi    (m0_araddr_hi),
    .m1_araddr_hi    (m1_araddr_hi),
    .m2_araddr_hi    (m2_araddr_hi),
    .s_arvalid       (s_arvalid),
    .s_arid          (s_arid),
    .s_arlen         (s_arlen),
    .m_arready       (m_arready),
    .m_rvalid        (m_rvalid),
    .m_rlast         (m_rlast),
    .s_rready        (s_rready),
    .ar_grant        (ar_grant),
    .s_araddr_en     (s_araddr_en),
    .rvalid_sel      (rvalid_sel),
    .m_rvalid_sel_en (m_rvalid_sel_en),
    .busy            (busy),
    .dec_arready     (dec_arready),
    .dec_rvalid      (dec_rvalid),
    .dec_rlast       (dec_rlast),
    .dec_rid         (dec_rid),
    .dec_rresp       (dec_rresp)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " grant"}, 32'(ar_grant), 32'd0);
    chk({tag, " ar_en"}, 32'(s_araddr_en), 32'd0);
    chk({tag, " rsel"}, 32'(rvalid_sel), 32'd0);
    chk({tag, " r_en"}, 32'(m_rvalid_sel_en), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  logic [2:0] rr_grant [4];
  logic [2:0] rr_sel   [4];
  logic       rdy_seq  [7];
  logic       last_seq [7];

  initial begin
    rr_grant = '{3'b001, 3'b010, 3'b100, 3'b001};
    rr_sel   = '{3'b010, 3'b100, 3'b001, 3'b010};
    rdy_seq  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    last_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    sys_rstn = 1'b0;
    m0_arvalid = 1'b1; m0_araddr_hi = 2'b10;
    m1_arvalid = 1'b0; m1_araddr_hi = 2'b11;
    m2_arvalid = 1'b0; m2_araddr_hi = 2'b01;
    s_arid = 4'd0; s_arlen = 8'd0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 1'b0;

    // Reset state and first grant
    step(); step();
    chk_idle("reset");
    chk("reset dec_rvalid", 32'(dec_rvalid), 32'd0);
    sys_rstn = 1'b1;
    step();
    chk("first grant", 32'(ar_grant), 32'b001);
    chk("first ar_en", 32'(s_araddr_en), 32'd1);
    chk("first r_en pre", 32'(m_rvalid_sel_en), 32'd0);
    m_arready = 1'b1;
    step();
    chk("first rsel", 32'(rvalid_sel), 32'b010);
    chk("first r_en", 32'(m_rvalid_sel_en), 32'd1);
    chk("first ar_en drop", 32'(s_araddr_en), 32'd0);
    m_arready = 1'b0; m0_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 1'b1;
    step();
    chk_idle("first done");
    m_rvalid = 1'b0; m_rlast = 1'b0;

    // Round robin from a fresh pointer
    sys_rstn = 1'b0;
    step();
    sys_rstn = 1'b1;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1; m2_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr%0d grant", i), 32'(ar_grant), 32'(rr_grant[i]));
      m_arready = 1'b1;
      step();
      chk($sformatf("rr%0d rsel", i), 32'(rvalid_sel), 32'(rr_sel[i]));
      m_arready = 1'b0;
      m_rvalid = 1'b1; m_rlast = 1'b1;
      step();
      chk($sformatf("rr%0d done", i), 32'(m_rvalid_sel_en), 32'd0);
      m_rvalid = 1'b0; m_rlast = 1'b0;
      if (i == 3) begin
        m1_arvalid = 1'b0; m2_arvalid = 1'b0; m0_araddr_hi = 2'b11;
      end
    end

    // 4-beat burst with gapped rready; m_rlast without rready must not end it
    step();
    chk("burst grant", 32'(ar_grant), 32'b001);
    m_arready = 1'b1;
    step();
    chk("burst rsel", 32'(rvalid_sel), 32'b100);
    m_arready = 1'b0; m0_arvalid = 1'b0;
    m_rvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_rready = rdy_seq[i]; m_rlast = last_seq[i];
      step();
      chk($sformatf("burst hold%0d", i), 32'({ar_grant, m_rvalid_sel_en}), 32'b0011);
    end
    s_rready = rdy_seq[6]; m_rlast = last_seq[6];
    step();
    chk_idle("burst done");
    m_rvalid = 1'b0; m_rlast = 1'b0;
    m1_arvalid = 1'b1; m1_araddr_hi = 2'b01;
    step();
    chk("gap grant", 32'(ar_grant), 32'b010);

    // AR stall for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall%0d", i), 32'({s_araddr_en, m_rvalid_sel_en}), 32'b10);
    end
    m_arready = 1'b1;
    step();
    chk("stall ar_en", 32'(s_araddr_en), 32'd0);
    chk("stall r_en", 32'(m_rvalid_sel_en), 32'd1);
    chk("stall rsel", 32'(rvalid_sel), 32'b001);
    m_arready = 1'b0;

    // Asynchronous reset mid-burst; pointer returns to m2 so m0 wins over m1
    m0_arvalid = 1'b1; m0_araddr_hi = 2'b10;
    m_rvalid = 1'b1; m_rlast = 1'b0;
    step();
    chk("midburst r_en", 32'(m_rvalid_sel_en), 32'd1);
    #2 sys_rstn = 1'b0;
    #1;
    chk_idle("async reset");
    m_rvalid = 1'b0;
    step();
    sys_rstn = 1'b1;
    step();
    chk("post reset grant", 32'(ar_grant), 32'b001);
    m_arready = 1'b1;
    step();
    m_arready = 1'b0; m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1;
    step();
    chk_idle("post reset done");
    m_rvalid = 1'b0; m_rlast = 1'b0;

    // Unmapped request (addr_hi = 00) from m2
    m2_arvalid = 1'b1; m2_araddr_hi = 2'b00; s_arid = 4'd5; s_arlen = 8'd2;
`ifdef AXI_RD_DECERR_EN
    step();
    chk("dec grant", 32'(ar_grant), 32'b100);
    chk("dec arready", 32'(dec_arready), 32'd1);
    chk("dec ar_en", 32'(s_araddr_en), 32'd0);
    step();
    chk("dec arready pulse", 32'(dec_arready), 32'd0);
    m2_arvalid = 1'b0;
    chk("dec beat1", 32'({dec_rvalid, dec_rlast, dec_rresp, dec_rid}), 32'b10_11_0101);
    step();
    chk("dec beat2", 32'({dec_rvalid, dec_rlast, dec_rresp, dec_rid}), 32'b10_11_0101);
    step();
    chk("dec beat3", 32'({dec_rvalid, dec_rlast, dec_rresp, dec_rid}), 32'b11_11_0101);
    step();
    chk("dec done rvalid", 32'(dec_rvalid), 32'd0);
    chk_idle("dec done");
`else
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("masked%0d", i), 32'({ar_grant, busy, s_araddr_en}), 32'd0);
    end
    chk("masked dec", 32'({dec_arready, dec_rvalid, dec_rlast, dec_rid, dec_rresp}), 32'd0);
    m2_arvalid = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
